// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared encodings for the instruction/data memory bus arbiter
package mem_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // On a tie the port that did not own the previous transaction wins.
    function automatic owner_e pick_owner(input logic inst_req, input logic data_req,
                                          input owner_e last_owner);
        if (inst_req && data_req) begin
            return (last_owner == OWN_INST) ? OWN_DATA : OWN_INST;
        end else if (data_req) begin
            return OWN_DATA;
        end
        return OWN_INST;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-outstanding arbiter sharing one SRAM-like bus between fetch and data ports
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              addr_ok, data_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INST;
            last_owner_q <= OWN_INST;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        addr_ok      = 1'b0;
        data_ok      = 1'b0;
        bus_req      = 1'b0;
        bus_wr       = 1'b0;
        bus_size     = 2'd0;
        bus_addr     = '0;
        bus_wdata    = '0;
        case (state_q)
            ST_IDLE: begin
                if (inst_req || data_req) begin
                    owner_d = pick_owner(inst_req, data_req, last_owner_q);
                    if (owner_d == OWN_DATA) begin
                        wr_d    = data_wr;
                        size_d  = data_size;
                        addr_d  = data_addr;
                        wdata_d = data_wdata;
                    end else begin
                        wr_d    = 1'b0;
                        size_d  = SZ_W;
                        addr_d  = inst_addr;
                        wdata_d = '0;
                    end
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                bus_req   = 1'b1;
                bus_wr    = wr_q;
                bus_size  = size_q;
                bus_addr  = addr_q;
                bus_wdata = wdata_q;
                // A data ack without the address ack is not for this transaction.
                if (bus_addr_ok) begin
                    addr_ok      = 1'b1;
                    last_owner_d = owner_q;
                    data_ok      = bus_data_ok;
                    state_d      = bus_data_ok ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus_data_ok) begin
                    data_ok = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign inst_addr_ok = addr_ok && (owner_q == OWN_INST);
    assign inst_data_ok = data_ok && (owner_q == OWN_INST);
    assign data_addr_ok = addr_ok && (owner_q == OWN_DATA);
    assign data_data_ok = data_ok && (owner_q == OWN_DATA);
    assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
    assign data_rdata   = data_data_ok ? bus_rdata : '0;

endmodule
